// File: rtl/mandelbrot_pixel_writer.sv
// Buffers finished Mandelbrot pixels in a small FIFO and writes their 3-3-2 colour
// into the VGA pixel SRAM through a waitrequest-style write port.
module mandelbrot_pixel_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fin_val,
  input  logic [10:0] single_num_iter,
  input  logic [9:0]  single_x,
  input  logic [9:0]  single_y,
  input  logic [31:0] max_iter,
  output logic [18:0] sram_address,
  output logic [7:0]  sram_writedata,
  output logic        sram_write,
  input  logic        sram_waitrequest,
  output logic [3:0]  fifo_count,
  output logic        overflow,
  output logic        frame_done,
  output logic [18:0] pixels_written
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned TOTAL = H_RES * V_RES;

  typedef struct packed {
    logic [10:0] n;
    logic [9:0]  y;
    logic [9:0]  x;
  } pix_t;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state, next_state;
  pix_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_empty_c, in_range_c, push_c, pop_c, accept_c;
  pix_t             head_c;

  function automatic logic [7:0] colour_of(input logic [10:0] n, input logic [31:0] m);
    logic [31:0] nz;
    nz = 32'(n);
    if      (nz >= m)        return 8'h00;
    else if (nz >= (m >> 1)) return 8'hE0;
    else if (nz >= (m >> 2)) return 8'hF0;
    else if (nz >= (m >> 3)) return 8'hFC;
    else if (nz >= (m >> 4)) return 8'h1C;
    else if (nz >= (m >> 5)) return 8'h1F;
    else if (nz >= (m >> 6)) return 8'h03;
    else                     return 8'h02;
  endfunction

  function automatic logic [18:0] addr_of(input pix_t p);
    return 19'(32'(p.y) * H_RES + 32'(p.x));
  endfunction

  assign fifo_empty_c = (fifo_count == 4'd0);
  assign head_c       = mem[rd_ptr];
  assign in_range_c   = (32'(single_x) < H_RES) && (32'(single_y) < V_RES);
  // A full FIFO still takes a new pixel when the writer frees a slot this cycle
  assign push_c       = fin_val && in_range_c && ((32'(fifo_count) < FIFO_DEPTH) || pop_c);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop_c      = 1'b0;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty_c) begin
          pop_c      = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (!sram_waitrequest) begin
          accept_c = 1'b1;
          if (!fifo_empty_c) pop_c      = 1'b1;
          else               next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c && !reset) mem[wr_ptr] <= '{n: single_num_iter, y: single_y, x: single_x};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      sram_address   <= '0;
      sram_writedata <= '0;
      sram_write     <= 1'b0;
      overflow       <= 1'b0;
      frame_done     <= 1'b0;
      pixels_written <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + 4'(push_c) - 4'(pop_c);
      if (fin_val && in_range_c && !push_c) overflow <= 1'b1;

      if (pop_c) begin
        sram_address   <= addr_of(head_c);
        sram_writedata <= colour_of(head_c.n, max_iter);
        sram_write     <= 1'b1;
      end else if (accept_c) begin
        sram_write <= 1'b0;
      end

      // Count saturates at a full frame; later writes still go out uncounted
      if (accept_c && (32'(pixels_written) < TOTAL)) begin
        pixels_written <= pixels_written + 19'd1;
        if (32'(pixels_written) + 32'd1 == TOTAL) frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_pixel_writer.sv
// Randomised and directed checks of mandelbrot_pixel_writer against a queue-based
// reference model; a second small-frame instance exercises frame completion.
module tb_mandelbrot_pixel_writer;

  logic        clk = 1'b0;
  logic        reset, fin_val, sram_waitrequest;
  logic [10:0] single_num_iter;
  logic [9:0]  single_x, single_y;
  logic [31:0] max_iter;
  logic [18:0] sram_address, pixels_written;
  logic [7:0]  sram_writedata;
  logic        sram_write, overflow, frame_done;
  logic [3:0]  fifo_count;

  logic        f_reset, f_fin_val;
  logic [9:0]  f_x, f_y;
  logic [18:0] f_address, f_pixels_written;
  logic [7:0]  f_writedata;
  logic        f_write, f_overflow, f_frame_done;
  logic [3:0]  f_fifo_count;

  always #5 clk = ~clk;

  mandelbrot_pixel_writer dut (
    .clk(clk), .reset(reset), .fin_val(fin_val), .single_num_iter(single_num_iter),
    .single_x(single_x), .single_y(single_y), .max_iter(max_iter),
    .sram_address(sram_address), .sram_writedata(sram_writedata), .sram_write(sram_write),
    .sram_waitrequest(sram_waitrequest), .fifo_count(fifo_count), .overflow(overflow),
    .frame_done(frame_done), .pixels_written(pixels_written)
  );

  mandelbrot_pixel_writer #(.FIFO_DEPTH(4), .H_RES(16), .V_RES(8)) dut_f (
    .clk(clk), .reset(f_reset), .fin_val(f_fin_val), .single_num_iter(11'd3),
    .single_x(f_x), .single_y(f_y), .max_iter(32'd100),
    .sram_address(f_address), .sram_writedata(f_writedata), .sram_write(f_write),
    .sram_waitrequest(1'b0), .fifo_count(f_fifo_count), .overflow(f_overflow),
    .frame_done(f_frame_done), .pixels_written(f_pixels_written)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending pixels as a queue plus the one write in flight
  typedef struct {int x; int y; logic [10:0] n;} ref_pix_t;
  ref_pix_t    q[$];
  bit          m_busy, m_ovf, m_fd;
  int          m_pw;
  logic [18:0] m_addr;
  logic [7:0]  m_data;
  logic [26:0] dut_log[$];

  function automatic logic [7:0] colour_ref(input logic [10:0] n, input logic [31:0] m);
    logic [7:0]  tbl [6];
    logic [31:0] nn;
    tbl = '{8'hE0, 8'hF0, 8'hFC, 8'h1C, 8'h1F, 8'h03};
    nn = {21'd0, n};
    if (nn >= m) return 8'h00;
    for (int k = 1; k <= 6; k++) if (nn >= (m >> k)) return tbl[k-1];
    return 8'h02;
  endfunction

  task automatic cycle();
    bit acc, pop, inr, push_ok;
    ref_pix_t p;
    if (!reset && sram_write && !sram_waitrequest) dut_log.push_back({sram_address, sram_writedata});
    @(posedge clk);
    if (reset) begin
      q.delete(); m_busy = 0; m_ovf = 0; m_fd = 0; m_pw = 0;
    end else begin
      acc     = m_busy && !sram_waitrequest;
      pop     = (q.size() > 0) && (!m_busy || !sram_waitrequest);
      inr     = fin_val && (single_x < 10'd640) && (single_y < 10'd480);
      push_ok = inr && ((q.size() < 8) || pop);
      if (acc) begin
        if (m_pw < 307200) m_pw++;
        if (m_pw == 307200) m_fd = 1;
        if (!pop) m_busy = 0;
      end
      if (pop) begin
        p = q.pop_front();
        m_busy = 1;
        m_addr = 19'(p.y * 640 + p.x);
        m_data = colour_ref(p.n, max_iter);
      end
      if (push_ok) q.push_back('{x: int'(single_x), y: int'(single_y), n: single_num_iter});
      else if (inr) m_ovf = 1;
    end
    #1;
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("sram_write", 32'(sram_write), 32'(m_busy));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("pixels_written", 32'(pixels_written), 32'(m_pw));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    if (m_busy) begin
      check("sram_address", 32'(sram_address), 32'(m_addr));
      check("sram_writedata", 32'(sram_writedata), 32'(m_data));
    end
  endtask

  task automatic push(input int x, input int y, input int n);
    fin_val = 1'b1; single_x = 10'(x); single_y = 10'(y); single_num_iter = 11'(n);
    cycle();
    fin_val = 1'b0;
  endtask

  initial begin
    logic [7:0] bins_exp [7];
    int         bins_n   [7];
    int         exp_pw;
    bins_exp = '{8'hE0, 8'hF0, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'h02};
    bins_n   = '{200, 70, 40, 20, 10, 5, 1};

    reset = 1'b1; f_reset = 1'b1; fin_val = 1'b0; f_fin_val = 1'b0;
    single_x = '0; single_y = '0; single_num_iter = '0; f_x = '0; f_y = '0;
    max_iter = 32'd1000; sram_waitrequest = 1'b0;
    cycle(); cycle();
    reset = 1'b0; f_reset = 1'b0;
    check("rst_address", 32'(sram_address), 32'd0);
    check("rst_writedata", 32'(sram_writedata), 32'd0);
    check("rst_write", 32'(sram_write), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_pixels", 32'(pixels_written), 32'd0);

    // Single pixel
    push(5, 2, 1000);
    check("single_count_after_push", 32'(fifo_count), 32'd1);
    repeat (4) cycle();
    check("single_nwrites", 32'(dut_log.size()), 32'd1);
    if (dut_log.size() > 0) check("single_write", 32'(dut_log[0]), 32'({19'd1285, 8'h00}));
    check("single_pixels", 32'(pixels_written), 32'd1);
    dut_log.delete();

    // Colour bins
    max_iter = 32'd256;
    for (int i = 0; i < 7; i++) push(i, 1, bins_n[i]);
    repeat (6) cycle();
    check("bins_nwrites", 32'(dut_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < dut_log.size(); i++)
      check($sformatf("bin%0d_data", i), 32'(dut_log[i][7:0]), 32'(bins_exp[i]));
    dut_log.delete();

    // Out of range
    push(640, 0, 5);
    push(0, 480, 5);
    repeat (3) cycle();
    check("oor_nwrites", 32'(dut_log.size()), 32'd0);
    check("oor_overflow", 32'(overflow), 32'd0);

    // Backpressure: first write held while the FIFO fills and one pixel drops
    sram_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) push(i, 10, 300 + i);
    check("bp_count_full", 32'(fifo_count), 32'd8);
    check("bp_overflow", 32'(overflow), 32'd1);
    repeat (10) cycle();
    sram_waitrequest = 1'b0;
    repeat (12) cycle();
    check("bp_nwrites", 32'(dut_log.size()), 32'd9);
    for (int i = 0; i < 9 && i < dut_log.size(); i++)
      check($sformatf("bp_addr%0d", i), 32'(dut_log[i][26:8]), 32'(10 * 640 + i));
    dut_log.delete();

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15, 0) == 0) max_iter = 32'($urandom_range(2048, 0));
      sram_waitrequest = ($urandom_range(3, 0) == 0);
      fin_val = ($urandom_range(1, 0) == 1);
      single_x = 10'($urandom_range(659, 0));
      single_y = 10'($urandom_range(489, 0));
      single_num_iter = 11'($urandom);
      cycle();
    end
    fin_val = 1'b0; sram_waitrequest = 1'b0;
    repeat (12) cycle();
    dut_log.delete();

    // Reset abandons a write in flight and clears the queue
    sram_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) push(20 + i, 7, 9);
    check("rmw_count", 32'(fifo_count), 32'd3);
    check("rmw_write", 32'(sram_write), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rmw_write_after_rst", 32'(sram_write), 32'd0);
    check("rmw_count_after_rst", 32'(fifo_count), 32'd0);
    check("rmw_overflow_after_rst", 32'(overflow), 32'd0);
    sram_waitrequest = 1'b0;
    dut_log.delete();
    push(3, 4, 50);
    repeat (4) cycle();
    check("rmw_nwrites", 32'(dut_log.size()), 32'd1);
    if (dut_log.size() > 0) check("rmw_addr", 32'(dut_log[0][26:8]), 32'(4 * 640 + 3));

    // Small-frame instance: one pixel per cycle, each accepted two edges after its push
    for (int t = 0; t <= 140; t++) begin
      f_fin_val = (t < 133);
      f_x = 10'(t % 16);
      f_y = 10'((t / 16) % 8);
      @(posedge clk);
      #1;
      exp_pw = (t < 1) ? 0 : ((t - 1 > 128) ? 128 : t - 1);
      check($sformatf("frame_pixels_t%0d", t), 32'(f_pixels_written), 32'(exp_pw));
      check($sformatf("frame_done_t%0d", t), 32'(f_frame_done), 32'(exp_pw == 128));
      check($sformatf("frame_overflow_t%0d", t), 32'(f_overflow), 32'd0);
    end
    f_fin_val = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mandelbrot_pixel_writer.md
Name: mandelbrot_pixel_writer

Overview:
- Sits directly downstream of the Mandelbrot iterator controller.
- Consumes each finished-pixel pulse (fin_val with x, y, iteration count) and buffers it in a small FIFO.
- Maps the iteration count to an 8-bit 3-3-2 colour and writes it to the VGA pixel SRAM through a waitrequest-style write port.
- Tracks frame completion and reports FIFO overflow.

Parameters:
FIFO_DEPTH, 8, number of buffered pixel entries; power of 2, minimum 2.
H_RES, 640, pixels per line; used for bounds check and address stride.
V_RES, 480, lines per frame; used for bounds check.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
fin_val  input  1  one-cycle pulse: a pixel result is valid this cycle
single_num_iter  input  11  iteration count of the finished pixel
single_x  input  10  pixel column
single_y  input  10  pixel row
max_iter  input  32  iteration limit currently in use by the iterators; sampled when a pixel is popped
sram_address  output  19  pixel address, y*H_RES + x
sram_writedata  output  8  colour, RRRGGGBB
sram_write  output  1  write request; held high until accepted
sram_waitrequest  input  1  high = SRAM stalls the current write
fifo_count  output  4  number of entries currently held
overflow  output  1  sticky; set when a pixel is dropped because the FIFO is full
frame_done  output  1  high once H_RES*V_RES pixels have been written; stays high until reset
pixels_written  output  19  count of SRAM writes accepted

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: sram_address=0, sram_writedata=0, sram_write=0, fifo_count=0, overflow=0, frame_done=0, pixels_written=0.
  - Writer goes to IDLE. FIFO pointers are cleared.
  - A write in flight is abandoned: sram_write drops on the cycle after reset is sampled.
- Push (on the same edge that fin_val is sampled high):
  - Input pixel is out of range (x >= H_RES or y >= V_RES): silently discarded, no count change, no overflow.
  - Otherwise pushed if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Else dropped and overflow set.
- Pop: the writer pops only in the two cases described under Writer FSM. Simultaneous push and pop leaves fifo_count unchanged.
- Colour map, computed at pop time from num_iter n and max_iter M:
  - n >= M -> 8'h00
  - n >= M>>1 -> 8'hE0
  - n >= M>>2 -> 8'hF0
  - n >= M>>3 -> 8'hFC
  - n >= M>>4 -> 8'h1C
  - n >= M>>5 -> 8'h1F
  - n >= M>>6 -> 8'h03
  - else -> 8'h02
  - n is zero-extended to 32 bits for all comparisons.
- Address: y*H_RES + x in 19 bits. For 640 this may be built as (y<<9)+(y<<7)+x; no multiplier required.
- Writer FSM:
  - IDLE: if FIFO is non-empty, pop, load sram_address/sram_writedata, set sram_write=1, go to WRITE.
  - WRITE: if sram_waitrequest=1, hold address, data and sram_write stable.
  - WRITE, sram_waitrequest=0: the write is accepted and pixels_written increments.
    - FIFO non-empty: pop the next entry in the same cycle and stay in WRITE, giving back-to-back writes at 1 pixel/cycle.
    - FIFO empty: sram_write=0, go to IDLE.
- Latency: fin_val sampled at edge N into an empty FIFO with the writer IDLE -> entry visible at N+1 (fifo_count=1) -> sram_write high in the cycle after edge N+1 (from edge N+2 view: first acceptance at edge N+2 if waitrequest=0).
- frame_done:
  - Set in the cycle pixels_written reaches H_RES*V_RES (307200).
  - pixels_written saturates at 307200; later writes still occur but are not counted.
- overflow is sticky and cleared only by reset.

Test Plan:
- Single pixel: reset, then fin_val for one cycle with x=5, y=2, n=1000, M=1000 -> one write with sram_address=1285, sram_writedata=8'h00; fifo_count returns to 0; pixels_written=1.
- Colour bins: M=256, push n=200, 70, 40, 20, 10, 5, 1 -> writedata sequence E0, F0, FC, 1C, 1F, 03, 02.
- Backpressure: hold sram_waitrequest=1 for 20 cycles and push 10 pixels on consecutive cycles -> first write held stable throughout; 8 remaining pixels fill the FIFO and 1 is dropped (overflow=1); after release, 9 writes complete back-to-back in FIFO order.
- Out of range: push x=640, y=0 and x=0, y=480 -> no write, fifo_count=0, overflow=0.
- Full frame: stream all 307200 in-range pixels with waitrequest=0 -> frame_done rises with the 307200th acceptance; pixels_written=307200; overflow=0.
- Reset mid-write: waitrequest=1 with a write pending and 3 entries queued, then reset -> next cycle sram_write=0, fifo_count=0; a new push after reset writes normally.
